div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Sequences the 32-cycle iterative divider (start/busy/q/r interface) for DIV/DIVU in the EX stage of the Citrus CPU.
- Handles operand sign conversion, divide-by-zero bypass, the pipeline stall, flush/cancel, and the result handshake.
- Sits between EX-stage issue logic and the divider instance. Owns the divider's start, a and b inputs.

Parameters:
- WIDTH, 32, operand/result width.
- TIMEOUT, 40, max cycles spent in any divider-wait state before abandoning with err.

Ports:
- clock  in  1  system clock
- resetn  in  1  async active-low reset
- req_valid  in  1  divide request from EX
- req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready & ~flush
- req_signed  in  1  1 = DIV (two's complement), 0 = DIVU
- req_a  in  WIDTH  dividend
- req_b  in  WIDTH  divisor
- flush  in  1  cancel in-flight op (exception/branch flush)
- stall  out  1  pipeline hold while an accepted op is unfinished
- res_valid  out  1  one-cycle result strobe
- res_q  out  WIDTH  quotient (LO)
- res_r  out  WIDTH  remainder (HI)
- err  out  1  one-cycle pulse on divider timeout
- div_a  out  WIDTH  divider dividend (magnitude)
- div_b  out  WIDTH  divider divisor (magnitude)
- div_start  out  1  divider start, one cycle
- div_busy  in  1  divider busy
- div_q  in  WIDTH  divider quotient
- div_r  in  WIDTH  divider remainder

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is clock. All outputs reset to 0, state to IDLE, internal registers to 0. Reset mid-operation abandons the op and produces no res_valid. The divider shares resetn.
- Divider contract: div_start sampled at an edge; div_busy rises at that edge and falls 32 edges later. div_q/div_r are valid while div_busy is low after the fall.
- States:
  - IDLE: req_ready=1. On accept, latch signed flag, sign_q = a[31]^b[31] (signed only), sign_r = a[31] (signed only).
    - If req_b==0: load res_q=all-ones, res_r=req_a, go to DONE.
    - Otherwise: load div_a/div_b with magnitudes (abs if signed, raw if unsigned), go to LAUNCH.
  - LAUNCH: div_start=1 for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: go to RUN when div_busy=1.
  - RUN: when div_busy=0, register res_q = sign_q ? -div_q : div_q and res_r = sign_r ? -div_r : div_r, then go to DONE.
  - DONE: res_valid = ~flush. Go to IDLE next cycle.
  - DRAIN: divider running for a cancelled op. Exit to IDLE when seen_busy && ~div_busy. seen_busy is set once div_busy=1 is sampled after launch.
- Cycle counts:
  - Normal latency: accept at edge E0, LAUNCH during E0–E1, res_valid during the cycle after E34.
  - Divide-by-zero: res_valid in the cycle after E0; div_start never asserted.
- stall = state in {LAUNCH, WAIT_BUSY, RUN}. Deasserted in DONE so the instruction retires with the result.
- Flush handling:
  - In LAUNCH, WAIT_BUSY or RUN: go to DRAIN. No res_valid, no err, stall drops next cycle.
  - In DONE: res_valid suppressed.
  - In IDLE: blocks acceptance.
  - req_ready stays 0 through DRAIN, so a new op never overlaps the cancelled one.
- Timeout: a cycle counter is cleared on entry to LAUNCH. If the count reaches TIMEOUT in WAIT_BUSY, RUN or DRAIN: pulse err for one cycle, go to IDLE, and give no res_valid.
- Arithmetic:
  - abs/neg are WIDTH-bit two's complement with wrap. abs(0x80000000) = 0x80000000, which is correct as an unsigned magnitude.
  - Quotient sign is dividend XOR divisor sign; remainder takes the dividend sign.
- res_q/res_r hold their last value until the next load.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT_BUSY, RUN, DONE, DRAIN);
  - DIV_ITER=32;
  - the divide-by-zero constants (quotient all-ones, remainder = dividend).
- Sub-module div_sign_fix: combinational abs-in / conditional-negate-out helper. Instantiated once for operands (x2 lanes) and once for results.
- FSM, counter and result registers live in div_sequencer.

Test Plan:
- DIVU 100/7 → div_start one cycle after accept; res_valid exactly after E34; q=14, r=2; stall high for LAUNCH..RUN only.
- DIV 0xFFFFFFF9 (-7) / 2 → q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). DIV 7/0xFFFFFFFE → q=0xFFFFFFFD, r=1.
- DIV 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0. DIVU 0xFFFFFFFF / 0x10 → q=0x0FFFFFFF, r=0xF.
- DIVU 5/0 → no div_start; res_valid the cycle after accept; q=0xFFFFFFFF, r=5.
- flush during RUN (E10) → no res_valid; req_ready stays 0 until div_busy falls; a back-to-back DIVU 9/3 then gives q=3, r=0.
- resetn low during RUN → all outputs 0 immediately. Tie div_busy=1 stuck → err pulse at TIMEOUT, return to IDLE, no res_valid.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state type and constants for the divide sequencer
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    RUN,
    DONE,
    DRAIN
  } div_state_t;

  localparam int DIV_ITER = 32;

  // Divide-by-zero result: quotient is all ones, remainder is the dividend itself.
  localparam logic [63:0] DIV0_Q = '1;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - two-lane conditional two's complement negate (abs in, signed fix-up out)
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_a_neg,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_b_neg,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b
);

  // Wraps at WIDTH bits, so the most negative value maps to itself.
  assign o_a = i_a_neg ? -i_a : i_a;
  assign o_b = i_b_neg ? -i_b : i_b;

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - EX-stage sequencer for the 32-cycle iterative divider (DIV/DIVU)
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             stall,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_q,
  output logic [WIDTH-1:0] res_r,
  output logic             err,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_start,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  div_state_t       r_state;
  div_state_t       w_next;
  logic [CW-1:0]    r_count;
  logic             r_seen_busy;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_div_a;
  logic [WIDTH-1:0] r_div_b;
  logic [WIDTH-1:0] r_res_q;
  logic [WIDTH-1:0] r_res_r;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_fix_q;
  logic [WIDTH-1:0] w_fix_r;
  logic             w_accept;
  logic             w_b_zero;
  logic             w_in_wait;
  logic             w_timeout;
  logic             w_err;

  div_sign_fix #(.WIDTH(WIDTH)) u_operand_fix (
    .i_a     (req_a),
    .i_a_neg (req_signed & req_a[WIDTH-1]),
    .i_b     (req_b),
    .i_b_neg (req_signed & req_b[WIDTH-1]),
    .o_a     (w_mag_a),
    .o_b     (w_mag_b)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
    .i_a     (div_q),
    .i_a_neg (r_sign_q),
    .i_b     (div_r),
    .i_b_neg (r_sign_r),
    .o_a     (w_fix_q),
    .o_b     (w_fix_r)
  );

  // Gated by resetn so every output reads 0 while reset is held.
  assign req_ready = (r_state == IDLE) & resetn;
  assign w_accept  = req_valid & req_ready & ~flush;
  assign w_b_zero  = (req_b == '0);
  assign w_in_wait = r_state inside {WAIT_BUSY, RUN, DRAIN};
  assign w_timeout = w_in_wait & (r_count >= TO_CNT);

  assign stall     = r_state inside {LAUNCH, WAIT_BUSY, RUN};
  assign div_start = (r_state == LAUNCH);
  assign res_valid = (r_state == DONE) & ~flush;
  assign err       = w_err;
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  assign res_q     = r_res_q;
  assign res_r     = r_res_r;

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      IDLE:      if (w_accept) w_next = w_b_zero ? DONE : LAUNCH;
      LAUNCH:    w_next = flush ? DRAIN : WAIT_BUSY;
      WAIT_BUSY: begin
        if (w_timeout) begin
          w_next = IDLE;
          w_err  = 1'b1;
        end else if (flush) w_next = DRAIN;
        else if (div_busy)  w_next = RUN;
      end
      RUN: begin
        if (w_timeout) begin
          w_next = IDLE;
          w_err  = 1'b1;
        end else if (flush) w_next = DRAIN;
        else if (!div_busy) w_next = DONE;
      end
      DONE:      w_next = IDLE;
      DRAIN: begin
        // The cancelled op still owns the divider until its busy window closes.
        if (w_timeout) begin
          w_next = IDLE;
          w_err  = 1'b1;
        end else if (r_seen_busy && !div_busy) w_next = IDLE;
      end
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_seen_busy <= 1'b0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_res_q     <= '0;
      r_res_r     <= '0;
    end else begin
      r_state <= w_next;

      if (r_state == IDLE) begin
        r_count     <= '0;
        r_seen_busy <= 1'b0;
      end else if (r_state != DONE && !w_timeout) begin
        r_count <= r_count + CW'(1);
      end

      if (w_in_wait && div_busy) r_seen_busy <= 1'b1;

      if (w_accept) begin
        r_sign_q <= req_signed & (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
        r_sign_r <= req_signed & req_a[WIDTH-1];
        if (w_b_zero) begin
          r_res_q <= DIV0_Q[WIDTH-1:0];
          r_res_r <= req_a;
        end else begin
          r_div_a <= w_mag_a;
          r_div_b <= w_mag_b;
        end
      end

      if (r_state == RUN && w_next == DONE) begin
        r_res_q <= w_fix_q;
        r_res_r <= w_fix_r;
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed self-checking bench for div_sequencer with a behavioural divider
module tb_div_sequencer;
  import div_pkg::*;

  localparam int LAT_DIV  = DIV_ITER + 3;
  localparam int STALL_N  = DIV_ITER + 2;
  localparam int TO_AT    = 41;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        stall;
  logic        res_valid;
  logic [31:0] res_q;
  logic [31:0] res_r;
  logic        err;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_start;
  logic        div_busy;
  logic [31:0] div_q;
  logic [31:0] div_r;

  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        stuck_busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  div_sequencer #(.WIDTH(32), .TIMEOUT(40)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_signed (req_signed),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .stall      (stall),
    .res_valid  (res_valid),
    .res_q      (res_q),
    .res_r      (res_r),
    .err        (err),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_start  (div_start),
    .div_busy   (div_busy),
    .div_q      (div_q),
    .div_r      (div_r)
  );

  // Divider model: busy rises at the start edge, falls DIV_ITER edges later.
  assign div_busy = m_busy | stuck_busy;
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_a    <= '0;
      m_b    <= '0;
      div_q  <= '0;
      div_r  <= '0;
    end else if (div_start) begin
      m_busy <= 1'b1;
      m_cnt  <= DIV_ITER;
      m_a    <= div_a;
      m_b    <= div_b;
      div_q  <= 32'hDEAD_BEEF;
      div_r  <= 32'hDEAD_BEEF;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        div_q  <= (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b;
        div_r  <= (m_b == 0) ? m_a : m_a % m_b;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    req_valid  = 1'b1;
    req_signed = sgn;
    req_a      = a;
    req_b      = b;
  endtask

  task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input int exp_lat);
    int k = 0;
    int n_start = 0;
    int n_stall = 0;
    drive_req(sgn, a, b);
    for (int i = 1; i <= 60 && k == 0; i++) begin
      @(negedge clock);
      if (i == 1) begin
        chk1({name, "/ready_low"}, req_ready, 1'b0);
        req_valid = 1'b0;
      end
      n_start += int'(div_start);
      n_stall += int'(stall);
      if (res_valid) k = i;
    end
    chk({name, "/latency"}, k, exp_lat);
    chk({name, "/q"}, res_q, eq);
    chk({name, "/r"}, res_r, er);
    chk({name, "/starts"}, n_start, (exp_lat == 1) ? 0 : 1);
    chk({name, "/stall_cycles"}, n_stall, (exp_lat == 1) ? 0 : STALL_N);
    @(negedge clock);
    chk1({name, "/valid_drop"}, res_valid, 1'b0);
    chk1({name, "/ready_back"}, req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ready_at;
    int err_at;
    int n_errp;
    logic any_valid;

    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    req_a      = '0;
    req_b      = '0;
    flush      = 1'b0;
    stuck_busy = 1'b0;

    repeat (2) @(negedge clock);
    chk1("rst/req_ready", req_ready, 1'b0);
    chk1("rst/stall", stall, 1'b0);
    chk1("rst/res_valid", res_valid, 1'b0);
    chk1("rst/err", err, 1'b0);
    chk1("rst/div_start", div_start, 1'b0);
    chk("rst/res_q", res_q, 32'h0);
    chk("rst/div_a", div_a, 32'h0);
    resetn = 1'b1;
    @(negedge clock);
    chk1("idle/req_ready", req_ready, 1'b1);

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, LAT_DIV);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT_DIV);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, LAT_DIV);
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, LAT_DIV);
    run_op("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, LAT_DIV);
    run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
    run_op("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);

    // Flush in IDLE blocks acceptance.
    drive_req(1'b0, 32'd9, 32'd3);
    flush = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    flush     = 1'b0;
    chk1("idle_flush/ready", req_ready, 1'b1);
    chk1("idle_flush/div_start", div_start, 1'b0);

    // Flush during DONE suppresses the strobe.
    drive_req(1'b0, 32'd8, 32'd0);
    @(negedge clock);
    req_valid = 1'b0;
    flush     = 1'b1;
    #1;
    chk1("done_flush/res_valid", res_valid, 1'b0);
    @(negedge clock);
    flush = 1'b0;
    chk1("done_flush/valid_after", res_valid, 1'b0);
    chk1("done_flush/ready", req_ready, 1'b1);

    // Flush during RUN: drain until the divider finishes.
    ready_at  = 0;
    any_valid = 1'b0;
    drive_req(1'b0, 32'd1000, 32'd3);
    for (int i = 1; i <= 70 && ready_at == 0; i++) begin
      @(negedge clock);
      if (i == 1) req_valid = 1'b0;
      if (i == 10) flush = 1'b1;
      if (i == 11) begin
        flush = 1'b0;
        chk1("run_flush/stall_drop", stall, 1'b0);
      end
      if (res_valid) any_valid = 1'b1;
      if (req_ready) ready_at = i;
    end
    chk("run_flush/ready_at", ready_at, LAT_DIV);
    chk1("run_flush/no_valid", any_valid, 1'b0);
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, LAT_DIV);

    // Reset mid-operation.
    drive_req(1'b0, 32'd100, 32'd7);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (i == 1) req_valid = 1'b0;
    end
    resetn = 1'b0;
    #1;
    chk1("midrst/stall", stall, 1'b0);
    chk1("midrst/req_ready", req_ready, 1'b0);
    chk1("midrst/div_start", div_start, 1'b0);
    chk1("midrst/res_valid", res_valid, 1'b0);
    chk("midrst/div_a", div_a, 32'h0);
    chk("midrst/res_q", res_q, 32'h0);
    chk("midrst/res_r", res_r, 32'h0);
    repeat (2) @(negedge clock);
    resetn    = 1'b1;
    any_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (res_valid) any_valid = 1'b1;
    end
    chk1("midrst/no_valid", any_valid, 1'b0);
    chk1("midrst/ready", req_ready, 1'b1);

    // Divider stuck busy: timeout.
    stuck_busy = 1'b1;
    err_at     = 0;
    n_errp     = 0;
    ready_at   = 0;
    any_valid  = 1'b0;
    drive_req(1'b0, 32'd100, 32'd7);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (i == 1) req_valid = 1'b0;
      if (err) begin
        n_errp++;
        if (err_at == 0) err_at = i;
      end
      if (res_valid) any_valid = 1'b1;
      if (i == TO_AT + 1 && req_ready) ready_at = i;
    end
    stuck_busy = 1'b0;
    chk("timeout/err_at", err_at, TO_AT);
    chk("timeout/err_pulses", n_errp, 1);
    chk("timeout/ready_at", ready_at, TO_AT + 1);
    chk1("timeout/no_valid", any_valid, 1'b0);
    run_op("recover_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, LAT_DIV);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
